jk_op_driver: RTL and testbench
===============================

// Module: jk_op_driver
// PURPOSE
//  Upstream command stage for the JKflipflop cell: accepts abstract ops (hold/reset/set/toggle)
//  over a valid/ready handshake, drives j/k into the flop for exactly one clock edge, then samples
//  q/q1 and reports done plus a pass/fail flag against the expected next state. Keeps op and
//  error counters for lab self-checking of the flop.
// PARAMETERS
//  CNT_W     8  width of op_cnt and err_cnt (saturating)
//  CHECK_EN  1  1: compare q/q1 to expected; 0: compare disabled, err always 0
// PORTS
//  c         in   1      clock; all state updates on posedge c
//  rst_n     in   1      synchronous active-low reset, sampled on posedge c
//  op_valid  in   1      op request valid
//  op        in   2      {j,k} encoding: 00 hold, 01 reset, 10 set, 11 toggle
//  op_ready  out  1      high only in IDLE; op accepted on posedge when op_valid&&op_ready
//  j         out  1      to JKflipflop.j (registered)
//  k         out  1      to JKflipflop.k (registered)
//  q         in   1      from JKflipflop.q
//  q1        in   1      from JKflipflop.q1 (must equal ~q)
//  done      out  1      one-cycle pulse: op completed, err/q_exp valid in same cycle
//  err       out  1      valid with done: 1 = mismatch; held until next done
//  q_exp     out  1      expected q for the completed op; held until next done
//  op_cnt    out  CNT_W  completed ops, saturates at 2**CNT_W-1
//  err_cnt   out  CNT_W  ops with err=1, saturates at 2**CNT_W-1
// BEHAVIOUR
//  Reset (rst_n=0 at posedge c): state=IDLE, j=k=0, done=err=q_exp=0, op_cnt=err_cnt=0,
//   known=0. Reset wins over any in-flight op; aborted op is not counted, no done.
//  FSM IDLE -> DRIVE -> CHECK -> IDLE, one cycle per state:
//   IDLE: j=k=0. Edge A with op_valid: latch op, j<=op[1], k<=op[0], q_prev<=q, go DRIVE.
//   DRIVE: j/k stable for flop capture at edge A+1; at A+1 j<=0,k<=0, go CHECK.
//   CHECK: at edge A+2 sample q/q1, done<=1, update err/q_exp/counters, go IDLE.
//  Latency: done high in cycle after edge A+2. Throughput: 1 op / 3 cycles; next accept
//   earliest at A+3 (op_ready rises with done).
//  Expected q: hold->q_prev, reset->0, set->1, toggle->~q_prev.
//  known flag: flop has no reset, so q is undefined until first set/reset. known<=1 on
//   completion of set/reset; hold/toggle with known=0 -> err=0, q_exp=q (unchecked), counted.
//  err = CHECK_EN && ((known_or_setreset && q!=q_exp) || (q1 != ~q)).
//  op_valid outside IDLE ignored (no buffering); op changes while not ready have no effect.
//  Counters: op_cnt+1 every done; err_cnt+1 when err; both hold at all-ones.
//  done deasserts in following cycle; j/k never high outside DRIVE.
// TESTING
//  1 Reset: rst_n=0 2 cycles -> j=k=0, op_ready=1, done=0, op_cnt=err_cnt=0.
//  2 Seq reset,hold,set,hold,toggle (op=01,00,10,00,11) on good flop -> q_exp=0,0,1,1,0;
//    err=0 all; op_cnt=5, err_cnt=0; done exactly 2 edges after each accept.
//  3 First op toggle after reset (known=0) -> done, err=0; next op set -> q_exp=1, known=1.
//  4 Fault inject: force q1=q during set -> err=1, err_cnt=1; CHECK_EN=0 -> err=0.
//  5 op_valid held high continuously -> accepts every 3rd edge, op_ready low in DRIVE/CHECK.
//  6 rst_n=0 in DRIVE -> next cycle IDLE, j=k=0, no done, op_cnt unchanged at 0;
//    CNT_W=2: 5 ops -> op_cnt saturates at 3.

Source files
------------

// File: rtl/jk_op_driver.sv
// jk_op_driver
//   Command stage for a JK flip-flop cell under lab self-test. Accepts
//   abstract ops (hold/reset/set/toggle) over a valid/ready handshake. Each
//   accepted op drives j/k into the flop for exactly one clock edge. The
//   stage then samples q/q1 and reports done with a pass/fail flag against
//   the expected next state. Saturating op and error counters are kept.
//
// Handshake: an op transfers on a posedge of c where op_valid && op_ready.
//   op_ready is high only in IDLE. op_valid in any other state is ignored,
//   and op may change freely while op_ready is low.
//
// Ports
//   c          clock, all state updates on posedge
//   rst_n      synchronous active-low reset
//   op_valid   op request valid
//   op[1:0]    {j,k}: 00 hold, 01 reset, 10 set, 11 toggle
//   op_ready   high in IDLE only
//   j, k       registered drive to the flop, high only in DRIVE
//   q, q1      flop outputs (q1 must equal ~q)
//   done       one-cycle completion pulse
//   err        mismatch flag for the completed op, held until next done
//   q_exp      expected q for the completed op, held until next done
//   op_cnt     completed ops, saturating
//   err_cnt    ops completed with err=1, saturating
//   fsm_state  current FSM state (0 IDLE, 1 DRIVE, 2 CHECK) for observation
module jk_op_driver #(
  parameter int CNT_W    = 8,
  parameter bit CHECK_EN = 1'b1
) (
  input  logic             c,
  input  logic             rst_n,
  input  logic             op_valid,
  input  logic [1:0]       op,
  output logic             op_ready,
  output logic             j,
  output logic             k,
  input  logic             q,
  input  logic             q1,
  output logic             done,
  output logic             err,
  output logic             q_exp,
  output logic [CNT_W-1:0] op_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t     state;
  logic [1:0] op_r;
  logic       q_prev;
  logic       known;

  logic       set_reset;
  logic       checked;
  logic       exp_next;
  logic       q_exp_next;
  logic       err_next;

  assign op_ready  = (state == IDLE);
  assign fsm_state = state;

  // The flop has no reset, so its state means nothing until a set or reset
  // has completed. Before that, hold/toggle results are reported unchecked:
  // q_exp simply mirrors q. The q1 == ~q consistency check always applies.
  always_comb begin
    set_reset = (op_r == 2'b01) || (op_r == 2'b10);
    checked   = known || set_reset;
    case (op_r)
      2'b00:   exp_next = q_prev;
      2'b01:   exp_next = 1'b0;
      2'b10:   exp_next = 1'b1;
      default: exp_next = ~q_prev;
    endcase
    q_exp_next = checked ? exp_next : q;
    err_next   = CHECK_EN && ((checked && (q != exp_next)) || (q1 != ~q));
  end

  always_ff @(posedge c) begin
    if (!rst_n) begin
      state   <= IDLE;
      op_r    <= 2'b00;
      q_prev  <= 1'b0;
      known   <= 1'b0;
      j       <= 1'b0;
      k       <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      q_exp   <= 1'b0;
      op_cnt  <= '0;
      err_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          j <= 1'b0;
          k <= 1'b0;
          if (op_valid) begin
            op_r   <= op;
            j      <= op[1];
            k      <= op[0];
            q_prev <= q;
            state  <= DRIVE;
          end
        end
        DRIVE: begin
          // The flop captures j/k on this edge; release them immediately.
          j     <= 1'b0;
          k     <= 1'b0;
          state <= CHECK;
        end
        CHECK: begin
          done  <= 1'b1;
          err   <= err_next;
          q_exp <= q_exp_next;
          if (set_reset) known <= 1'b1;
          if (op_cnt != CNT_MAX) op_cnt <= op_cnt + 1'b1;
          if (err_next && (err_cnt != CNT_MAX)) err_cnt <= err_cnt + 1'b1;
          state <= IDLE;
        end
        default: begin
          j     <= 1'b0;
          k     <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jk_op_driver.sv
// tb_jk_op_driver
//   Directed bench for jk_op_driver. Three instances share one stimulus:
//   a: CNT_W=8, CHECK_EN=1 (main checks)
//   b: CNT_W=8, CHECK_EN=0 (compare disabled)
//   c: CNT_W=2, CHECK_EN=1 (counter saturation)
//   Each instance drives its own behavioural JK flop. 'fault' ties q1 to q.
//   'stuck' freezes every flop so that unchecked results can be observed.
module tb_jk_op_driver;

  logic       c;
  logic       rst_n;
  logic       op_valid;
  logic [1:0] op;
  logic       fault;
  logic       stuck;

  int n_vec;
  int n_fail;

  logic       op_ready_a, j_a, k_a, q_a, q1_a, done_a, err_a, q_exp_a;
  logic [7:0] op_cnt_a, err_cnt_a;
  logic [1:0] st_a;

  logic       op_ready_b, j_b, k_b, q_b, q1_b, done_b, err_b, q_exp_b;
  logic [7:0] op_cnt_b, err_cnt_b;
  logic [1:0] st_b;

  logic       op_ready_c, j_c, k_c, q_c, q1_c, done_c, err_c, q_exp_c;
  logic [1:0] op_cnt_c, err_cnt_c;
  logic [1:0] st_c;

  // ---------------- clock / reset ----------------
  initial c = 1'b0;
  always #5 c = ~c;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- flop models ----------------
  always @(posedge c) if (!stuck) begin
    case ({j_a, k_a})
      2'b01:   q_a <= 1'b0;
      2'b10:   q_a <= 1'b1;
      2'b11:   q_a <= ~q_a;
      default: ;
    endcase
  end
  always @(posedge c) if (!stuck) begin
    case ({j_b, k_b})
      2'b01:   q_b <= 1'b0;
      2'b10:   q_b <= 1'b1;
      2'b11:   q_b <= ~q_b;
      default: ;
    endcase
  end
  always @(posedge c) if (!stuck) begin
    case ({j_c, k_c})
      2'b01:   q_c <= 1'b0;
      2'b10:   q_c <= 1'b1;
      2'b11:   q_c <= ~q_c;
      default: ;
    endcase
  end
  assign q1_a = fault ? q_a : ~q_a;
  assign q1_b = fault ? q_b : ~q_b;
  assign q1_c = fault ? q_c : ~q_c;

  jk_op_driver #(.CNT_W(8), .CHECK_EN(1'b1)) u_a (
    .c(c), .rst_n(rst_n), .op_valid(op_valid), .op(op), .op_ready(op_ready_a),
    .j(j_a), .k(k_a), .q(q_a), .q1(q1_a), .done(done_a), .err(err_a),
    .q_exp(q_exp_a), .op_cnt(op_cnt_a), .err_cnt(err_cnt_a), .fsm_state(st_a)
  );
  jk_op_driver #(.CNT_W(8), .CHECK_EN(1'b0)) u_b (
    .c(c), .rst_n(rst_n), .op_valid(op_valid), .op(op), .op_ready(op_ready_b),
    .j(j_b), .k(k_b), .q(q_b), .q1(q1_b), .done(done_b), .err(err_b),
    .q_exp(q_exp_b), .op_cnt(op_cnt_b), .err_cnt(err_cnt_b), .fsm_state(st_b)
  );
  jk_op_driver #(.CNT_W(2), .CHECK_EN(1'b1)) u_c (
    .c(c), .rst_n(rst_n), .op_valid(op_valid), .op(op), .op_ready(op_ready_c),
    .j(j_c), .k(k_c), .q(q_c), .q1(q1_c), .done(done_c), .err(err_c),
    .q_exp(q_exp_c), .op_cnt(op_cnt_c), .err_cnt(err_cnt_c), .fsm_state(st_c)
  );

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge c);
    #1;
  endtask

  // Sends one op from IDLE, checking every cycle of the op on instance a.
  task automatic send_op(input string tag, input logic [1:0] o,
                         input logic qe, input logic er);
    chk({tag, " ready_idle"}, 32'(op_ready_a), 1);
    op_valid = 1'b1;
    op       = o;
    step();                                   // edge A
    op_valid = 1'b0;
    op       = $urandom_range(3, 0);          // must have no effect
    chk({tag, " st_drive"}, 32'(st_a), 1);
    chk({tag, " j_drive"}, 32'(j_a), 32'(o[1]));
    chk({tag, " k_drive"}, 32'(k_a), 32'(o[0]));
    chk({tag, " ready_drive"}, 32'(op_ready_a), 0);
    step();                                   // edge A+1
    chk({tag, " st_check"}, 32'(st_a), 2);
    chk({tag, " jk_check"}, 32'({j_a, k_a}), 0);
    chk({tag, " done_early"}, 32'(done_a), 0);
    step();                                   // edge A+2
    chk({tag, " done"}, 32'(done_a), 1);
    chk({tag, " q_exp"}, 32'(q_exp_a), 32'(qe));
    chk({tag, " err"}, 32'(err_a), 32'(er));
    chk({tag, " ready_done"}, 32'(op_ready_a), 1);
    step();
    chk({tag, " done_pulse"}, 32'(done_a), 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    n_vec    = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    op_valid = 1'b0;
    op       = 2'b00;
    fault    = 1'b0;
    stuck    = 1'b0;

    // 1: reset
    step();
    step();
    chk("rst jk", 32'({j_a, k_a}), 0);
    chk("rst ready", 32'(op_ready_a), 1);
    chk("rst done", 32'(done_a), 0);
    chk("rst op_cnt", 32'(op_cnt_a), 0);
    chk("rst err_cnt", 32'(err_cnt_a), 0);
    chk("rst c op_cnt", 32'(op_cnt_c), 0);
    rst_n = 1'b1;
    step();

    // 2: reset, hold, set, hold, toggle on a good flop
    send_op("s2 reset",  2'b01, 1'b0, 1'b0);
    send_op("s2 hold0",  2'b00, 1'b0, 1'b0);
    send_op("s2 set",    2'b10, 1'b1, 1'b0);
    send_op("s2 hold1",  2'b00, 1'b1, 1'b0);
    send_op("s2 toggle", 2'b11, 1'b0, 1'b0);
    chk("s2 op_cnt", 32'(op_cnt_a), 5);
    chk("s2 err_cnt", 32'(err_cnt_a), 0);
    chk("s2 c op_cnt sat", 32'(op_cnt_c), 3);

    // 3: toggle while state unknown (flop frozen at 0), then set
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    stuck = 1'b1;
    send_op("s3 toggle_unknown", 2'b11, 1'b0, 1'b0);
    stuck = 1'b0;
    send_op("s3 set", 2'b10, 1'b1, 1'b0);
    send_op("s3 toggle_known", 2'b11, 1'b0, 1'b0);
    chk("s3 op_cnt", 32'(op_cnt_a), 3);

    // 4: q1 forced equal to q during a set
    fault = 1'b1;
    send_op("s4 set_fault", 2'b10, 1'b1, 1'b1);
    fault = 1'b0;
    chk("s4 err_cnt", 32'(err_cnt_a), 1);
    chk("s4 b err", 32'(err_b), 0);
    chk("s4 b err_cnt", 32'(err_cnt_b), 0);
    chk("s4 c err", 32'(err_c), 1);
    chk("s4 c err_cnt", 32'(err_cnt_c), 1);
    chk("s4 c op_cnt sat", 32'(op_cnt_c), 3);

    // 5: op_valid held high, hold ops: accept every third edge
    op_valid = 1'b1;
    op       = 2'b00;
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("s5 ready %0d", i), 32'(op_ready_a), (i % 3 == 0) ? 1 : 0);
      chk($sformatf("s5 done %0d", i), 32'(done_a), (i % 3 == 0 && i > 0) ? 1 : 0);
      step();
    end
    op_valid = 1'b0;
    chk("s5 done last", 32'(done_a), 1);
    chk("s5 q_exp", 32'(q_exp_a), 1);
    chk("s5 op_cnt", 32'(op_cnt_a), 7);
    step();

    // 6: reset during DRIVE aborts the op
    op_valid = 1'b1;
    op       = 2'b10;
    step();
    op_valid = 1'b0;
    chk("s6 st_drive", 32'(st_a), 1);
    chk("s6 j_drive", 32'(j_a), 1);
    rst_n = 1'b0;
    step();
    chk("s6 st_idle", 32'(st_a), 0);
    chk("s6 jk", 32'({j_a, k_a}), 0);
    chk("s6 done", 32'(done_a), 0);
    chk("s6 op_cnt", 32'(op_cnt_a), 0);
    rst_n = 1'b1;
    step();
    chk("s6 done_after", 32'(done_a), 0);
    chk("s6 op_cnt_after", 32'(op_cnt_a), 0);
    send_op("s6 reset_after", 2'b01, 1'b0, 1'b0);
    chk("s6 op_cnt_final", 32'(op_cnt_a), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
